// File: rtl/operand_issue_pkg.sv
// rtl/operand_issue_pkg.sv - shared constants and types for the operand issue stage
// Purpose: register/data widths and a one-hot register decode helper.
// Ports: none (package).
package operand_issue_pkg;

  localparam int REG_W    = 3;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;

  typedef logic [REG_W-1:0]  reg_t;
  typedef logic [DATA_W-1:0] data_t;

  // One-hot mask for register r, all zeros when en is low.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_t r, input logic en);
    logic [NUM_REGS-1:0] m;
    m = '0;
    if (en) m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/operand_issue_if.sv
// rtl/operand_issue_if.sv - decode-side and execute-side op handshakes of the issue stage
// Purpose: groups the incoming decoded op (in_*) and the issued op (out_*).
// Ports: none; modport master = decode/execute side, modport slave = issue stage.
interface operand_issue_if #(
  parameter int CTL_W = 8
) ();

  logic                          in_vld;
  logic                          in_rdy;
  operand_issue_pkg::reg_t       in_rs1;
  logic                          in_use1;
  operand_issue_pkg::reg_t       in_rs2;
  logic                          in_use2;
  operand_issue_pkg::reg_t       in_rd;
  logic                          in_wr;
  logic                          in_long;
  logic [CTL_W-1:0]              in_ctl;

  logic                          out_vld;
  logic                          out_rdy;
  operand_issue_pkg::data_t      out_a;
  operand_issue_pkg::data_t      out_b;
  operand_issue_pkg::reg_t       out_rs1;
  operand_issue_pkg::reg_t       out_rs2;
  operand_issue_pkg::reg_t       out_rd;
  logic                          out_wr;
  logic                          out_long;
  logic [CTL_W-1:0]              out_ctl;

  modport master (
    output in_vld, in_rs1, in_use1, in_rs2, in_use2, in_rd, in_wr, in_long, in_ctl, out_rdy,
    input  in_rdy, out_vld, out_a, out_b, out_rs1, out_rs2, out_rd, out_wr, out_long, out_ctl
  );

  modport slave (
    input  in_vld, in_rs1, in_use1, in_rs2, in_use2, in_rd, in_wr, in_long, in_ctl, out_rdy,
    output in_rdy, out_vld, out_a, out_b, out_rs1, out_rs2, out_rd, out_wr, out_long, out_ctl
  );

endinterface

// File: rtl/operand_issue_scoreboard_8.sv
// rtl/operand_issue_scoreboard_8.sv - pending-writer scoreboard for long-latency results
// Purpose: one bit per register marking an outstanding long writer; three lookup ports.
// Ports: clk, rstn; set_vld/set_addr (writer leaves issue), clr_vld/clr_addr (writeback);
//        inflight_vld/inflight_addr (long writer still in the issue output register);
//        look_addr[3] in, pend[2:0] out.
module scoreboard_8
  import operand_issue_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       set_vld,
  input  reg_t       set_addr,
  input  logic       clr_vld,
  input  reg_t       clr_addr,
  input  logic       inflight_vld,
  input  reg_t       inflight_addr,
  input  reg_t       look_addr [3],
  output logic [2:0] pend
);

  logic [NUM_REGS-1:0] sb;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] live;

  assign set_mask = reg_onehot(set_addr, set_vld);
  assign clr_mask = reg_onehot(clr_addr, clr_vld);

  // Writeback is bypassed by the register file, so a same-cycle clear already
  // unblocks readers. The op still in the output register counts as pending.
  assign live = (sb | reg_onehot(inflight_addr, inflight_vld)) & ~clr_mask;

  always_comb begin
    pend = '0;
    for (int i = 0; i < 3; i++) pend[i] = live[look_addr[i]];
  end

  // Set applied after clear: a new writer leaving issue outranks the old result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sb <= '0;
    else       sb <= (sb & ~clr_mask) | set_mask;
  end

endmodule

// File: rtl/operand_issue.sv
// rtl/operand_issue.sv - register-read/issue stage with long-writer hazard stall
// Purpose: drives register file read addresses, captures operands into the ID/EX register,
//          stalls on RAW/WAW against scoreboarded long writers, counts stall cycles.
// Ports: clk, rstn; op (slave: in_* decoded op, out_* issued op);
//        raddr1/raddr2 out, rdata1/rdata2 in; wb_vld/wb_addr in; flush in; stall_cnt out.
module operand_issue
  import operand_issue_pkg::*;
#(
  parameter int CTL_W   = 8,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rstn,
  operand_issue_if.slave     op,
  output reg_t               raddr1,
  output reg_t               raddr2,
  input  data_t              rdata1,
  input  data_t              rdata2,
  input  logic               wb_vld,
  input  reg_t               wb_addr,
  input  logic               flush,
  output logic [STALL_W-1:0] stall_cnt
);

  logic             vld_q, wr_q, long_q;
  data_t            a_q, b_q;
  reg_t             rs1_q, rs2_q, rd_q;
  logic [CTL_W-1:0] ctl_q;

  reg_t       look [3];
  logic [2:0] pend;
  logic       hazard, in_rdy, accept, exit_long;

  assign raddr1 = op.in_rs1;
  assign raddr2 = op.in_rs2;

  always_comb begin
    look[0] = op.in_rs1;
    look[1] = op.in_rs2;
    look[2] = op.in_rd;
  end

  assign hazard    = (op.in_use1 & pend[0]) | (op.in_use2 & pend[1]) | (op.in_wr & pend[2]);
  assign in_rdy    = ~hazard & (~vld_q | op.out_rdy) & ~flush;
  assign accept    = op.in_vld & in_rdy;
  assign exit_long = vld_q & op.out_rdy & ~flush & wr_q & long_q;

  scoreboard_8 u_sb (
    .clk           (clk),
    .rstn          (rstn),
    .set_vld       (exit_long),
    .set_addr      (rd_q),
    .clr_vld       (wb_vld),
    .clr_addr      (wb_addr),
    .inflight_vld  (vld_q & wr_q & long_q),
    .inflight_addr (rd_q),
    .look_addr     (look),
    .pend          (pend)
  );

  // Data fields only change on acceptance, so they stay stable while held.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
      wr_q   <= 1'b0;
      long_q <= 1'b0;
      ctl_q  <= '0;
    end else if (accept) begin
      vld_q  <= 1'b1;
      a_q    <= rdata1;
      b_q    <= rdata2;
      rs1_q  <= op.in_rs1;
      rs2_q  <= op.in_rs2;
      rd_q   <= op.in_rd;
      wr_q   <= op.in_wr;
      long_q <= op.in_long;
      ctl_q  <= op.in_ctl;
    end else if (flush || op.out_rdy) begin
      vld_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                   stall_cnt <= '0;
    else if (op.in_vld && !in_rdy && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end

  assign op.in_rdy   = in_rdy;
  assign op.out_vld  = vld_q;
  assign op.out_a    = a_q;
  assign op.out_b    = b_q;
  assign op.out_rs1  = rs1_q;
  assign op.out_rs2  = rs2_q;
  assign op.out_rd   = rd_q;
  assign op.out_wr   = wr_q;
  assign op.out_long = long_q;
  assign op.out_ctl  = ctl_q;

endmodule
